// File: rtl/eink_spi_tx.sv
// SPI mode-0 byte transmitter for the e-ink panel: waits for BUSY to release before
// opening a frame, shifts MSB first, and holds CS_N low across multi-byte frames.
module eink_spi_tx #(
    parameter int CLK_DIV      = 2,
    parameter int BUSY_ACTIVE  = 1,
    parameter int BUSY_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_dc,
    input  logic       in_last,
    input  logic       busy_i,
    output logic       sck,
    output logic       mosi,
    output logic       cs_n,
    output logic       dc,
    output logic       byte_done,
    output logic       err_timeout
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WAIT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_TIMEOUT - 1);
    localparam logic BUSY_LVL = (BUSY_ACTIVE != 0);

    typedef enum logic [2:0] {IDLE, WAIT_BUSY, SETUP, SHIFT, HOLD} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [2:0]        bit_q, bit_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [7:0]        data_q, data_d;
    logic              dcl_q, dcl_d;
    logic              last_q, last_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              dc_q, dc_d;
    logic              byte_done_q, byte_done_d;
    logic              err_q, err_d;
    logic              sync1_q, busy_s_q;
    logic              busy;

    assign busy = (busy_s_q == BUSY_LVL);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        wait_d      = wait_q;
        data_d      = data_q;
        dcl_d       = dcl_q;
        last_d      = last_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        dc_d        = dc_q;
        byte_done_d = 1'b0;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d = in_data;
                    dcl_d  = in_dc;
                    last_d = in_last;
                    if (cs_n_q) begin
                        state_d = WAIT_BUSY;
                        wait_d  = '0;
                    end else begin
                        // Frame already open: skip the BUSY wait and load the pins directly
                        state_d = SETUP;
                        div_d   = '0;
                        cs_n_d  = 1'b0;
                        dc_d    = in_dc;
                        mosi_d  = in_data[7];
                        sck_d   = 1'b0;
                    end
                end
            end
            WAIT_BUSY: begin
                wait_d = wait_q + 1'b1;
                if (!busy || wait_q == WAIT_LAST) begin
                    if (busy) err_d = 1'b1;
                    state_d = SETUP;
                    div_d   = '0;
                    cs_n_d  = 1'b0;
                    dc_d    = dcl_q;
                    mosi_d  = data_q[7];
                    sck_d   = 1'b0;
                end
            end
            SETUP: begin
                if (div_q == DIV_LAST) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    sck_d   = 1'b1;
                    bit_d   = 3'd7;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (sck_q) begin
                        // Falling edge: present the next bit; bit0 stays on the line afterwards
                        sck_d = 1'b0;
                        if (bit_q != 3'd0) mosi_d = data_q[bit_q - 3'd1];
                    end else if (bit_q == 3'd0) begin
                        byte_done_d = 1'b1;
                        state_d     = last_q ? HOLD : IDLE;
                    end else begin
                        bit_d = bit_q - 3'd1;
                        sck_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HOLD: begin
                if (div_q == DIV_LAST) begin
                    cs_n_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            wait_q      <= '0;
            data_q      <= '0;
            dcl_q       <= 1'b0;
            last_q      <= 1'b0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            dc_q        <= 1'b0;
            byte_done_q <= 1'b0;
            err_q       <= 1'b0;
            sync1_q     <= ~BUSY_LVL;
            busy_s_q    <= ~BUSY_LVL;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            wait_q      <= wait_d;
            data_q      <= data_d;
            dcl_q       <= dcl_d;
            last_q      <= last_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            dc_q        <= dc_d;
            byte_done_q <= byte_done_d;
            err_q       <= err_d;
            sync1_q     <= busy_i;
            busy_s_q    <= sync1_q;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign sck         = sck_q;
    assign mosi        = mosi_q;
    assign cs_n        = cs_n_q;
    assign dc          = dc_q;
    assign byte_done   = byte_done_q;
    assign err_timeout = err_q;

endmodule
